// File: rtl/execute_pkg.sv
// Shared definitions for the execute stage: default widths, ALU op codes,
// branch condition codes, FSM states and the branch-compare helper.
package execute_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_MUL_CYC = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_MUL   = 4'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd4,
        BR_GE  = 3'd5,
        BR_LTU = 3'd6,
        BR_GEU = 3'd7
    } br_cond_e;

    typedef enum logic {
        ST_RUN,
        ST_MUL
    } state_e;

    // Width-independent: callers supply the three raw compare results.
    function automatic logic br_taken(input logic [2:0] cond, input logic eq,
                                      input logic lt, input logic ltu);
        case (cond)
            BR_EQ:   return eq;
            BR_NE:   return ~eq;
            BR_LT:   return lt;
            BR_GE:   return ~lt;
            BR_LTU:  return ltu;
            BR_GEU:  return ~ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/execute_if.sv
// Decode-to-execute bundle plus the registered execute outputs.
// master = decode/upstream side, slave = execute stage.
interface execute_if
    import execute_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic [ADDR_W-1:0] PC_in;
    logic              pipeline_in_valid;
    logic [3:0]        alu_op;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   imm;
    logic              is_branch;
    logic [2:0]        br_cond;
    logic              is_jal;
    logic              is_jalr;
    logic [4:0]        rd_addr_in;
    logic              rd_wr_in;
    logic              stall;

    logic              busy;
    logic [ADDR_W-1:0] PC_out;
    logic [XLEN-1:0]   result;
    logic [4:0]        rd_addr;
    logic              rd_wr;
    logic              pipeline_valid;
    logic              flush;
    logic [ADDR_W-1:0] flush_addr;

    modport master (
        output PC_in, pipeline_in_valid, alu_op, op_a, op_b, imm, is_branch,
               br_cond, is_jal, is_jalr, rd_addr_in, rd_wr_in, stall,
        input  busy, PC_out, result, rd_addr, rd_wr, pipeline_valid, flush,
               flush_addr
    );

    modport slave (
        input  PC_in, pipeline_in_valid, alu_op, op_a, op_b, imm, is_branch,
               br_cond, is_jal, is_jalr, rd_addr_in, rd_wr_in, stall,
        output busy, PC_out, result, rd_addr, rd_wr, pipeline_valid, flush,
               flush_addr
    );

endinterface

// File: rtl/execute_mul.sv
// Iterative shift-add multiplier (low XLEN bits). busy_o covers the iterations;
// done_o stays high with product_o stable until the next start_i.
module exec_mul #(
    parameter int XLEN    = 32,
    parameter int MUL_CYC = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int CW = $clog2(MUL_CYC + 1);

    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= CW'(MUL_CYC);
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/execute.sv
// Execute stage: ALU, branch/jump resolution, flush generation and output registers.
// Define EXEC_MUL_EN to add the iterative multiplier for alu_op 11.
module execute
    import execute_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int MUL_CYC = DEF_MUL_CYC
) (
    input logic      clk,
    input logic      reset,
    execute_if.slave bus
);

    logic [XLEN-1:0]   result_q;
    logic [ADDR_W-1:0] pcOut_q;
    logic [ADDR_W-1:0] flushAddr_q;
    logic [4:0]        rdAddr_q;
    logic              rdWr_q;
    logic              pipeValid_q;
    logic              flush_q;
    state_e            state_q;

    logic              accept;
    logic [4:0]        shamt;
    logic [XLEN-1:0]   aluResult_d;
    logic [ADDR_W-1:0] jalTarget_d;
    logic [ADDR_W-1:0] jalrTarget_d;
    logic [ADDR_W-1:0] linkAddr_d;
    logic              taken_d;

    // The instruction decode shows while flush is high is wrong-path and is refused here.
    assign accept = bus.pipeline_in_valid & ~bus.stall & ~flush_q & (state_q == ST_RUN);
    assign shamt  = bus.op_b[4:0];

    always_comb begin
        aluResult_d = '0;
        case (bus.alu_op)
            ALU_ADD:   aluResult_d = bus.op_a + bus.op_b;
            ALU_SUB:   aluResult_d = bus.op_a - bus.op_b;
            ALU_AND:   aluResult_d = bus.op_a & bus.op_b;
            ALU_OR:    aluResult_d = bus.op_a | bus.op_b;
            ALU_XOR:   aluResult_d = bus.op_a ^ bus.op_b;
            ALU_SLL:   aluResult_d = bus.op_a << shamt;
            ALU_SRL:   aluResult_d = bus.op_a >> shamt;
            ALU_SRA:   aluResult_d = $signed(bus.op_a) >>> shamt;
            ALU_SLT:   aluResult_d = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
            ALU_SLTU:  aluResult_d = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
            ALU_PASSB: aluResult_d = bus.op_b;
            default:   aluResult_d = '0;
        endcase
    end

    assign jalTarget_d  = bus.PC_in + ADDR_W'(bus.imm);
    assign jalrTarget_d = ADDR_W'(bus.op_a + bus.imm) & ~ADDR_W'(1);
    assign linkAddr_d   = bus.PC_in + ADDR_W'(4);
    assign taken_d      = bus.is_branch &
                          br_taken(bus.br_cond, bus.op_a == bus.op_b,
                                   $signed(bus.op_a) < $signed(bus.op_b), bus.op_a < bus.op_b);

`ifdef EXEC_MUL_EN
    logic            mulStart;
    logic            mulBusy;
    logic            mulDone;
    logic [XLEN-1:0] mulProduct;

    assign mulStart = accept & ~bus.is_jal & ~bus.is_jalr & ~bus.is_branch &
                      (bus.alu_op == ALU_MUL);

    exec_mul #(.XLEN(XLEN), .MUL_CYC(MUL_CYC)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mulStart),
        .a_i       (bus.op_a),
        .b_i       (bus.op_b),
        .busy_o    (mulBusy),
        .done_o    (mulDone),
        .product_o (mulProduct)
    );

    assign bus.busy = mulBusy;
`else
    assign bus.busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            pcOut_q     <= '0;
            flushAddr_q <= '0;
            rdAddr_q    <= '0;
            rdWr_q      <= 1'b0;
            pipeValid_q <= 1'b0;
            flush_q     <= 1'b0;
            state_q     <= ST_RUN;
        end else if (bus.stall) begin
            flush_q <= 1'b0;
`ifdef EXEC_MUL_EN
        end else if (state_q == ST_MUL) begin
            // PC/rd were captured at accept; only the product and valid land here.
            flush_q     <= 1'b0;
            pipeValid_q <= mulDone;
            if (mulDone) begin
                result_q <= mulProduct;
                state_q  <= ST_RUN;
            end
`endif
        end else if (accept) begin
            pcOut_q     <= bus.PC_in;
            rdAddr_q    <= bus.rd_addr_in;
            rdWr_q      <= bus.rd_wr_in;
            pipeValid_q <= 1'b1;
            flush_q     <= 1'b0;
            if (bus.is_jal) begin
                flush_q     <= 1'b1;
                flushAddr_q <= jalTarget_d;
                result_q    <= XLEN'(linkAddr_d);
            end else if (bus.is_jalr) begin
                flush_q     <= 1'b1;
                flushAddr_q <= jalrTarget_d;
                result_q    <= XLEN'(linkAddr_d);
            end else if (bus.is_branch) begin
                rdWr_q  <= 1'b0;
                flush_q <= taken_d;
                if (taken_d) begin
                    flushAddr_q <= jalTarget_d;
                end
`ifdef EXEC_MUL_EN
            end else if (bus.alu_op == ALU_MUL) begin
                pipeValid_q <= 1'b0;
                state_q     <= ST_MUL;
`endif
            end else begin
                result_q <= aluResult_d;
            end
        end else begin
            pipeValid_q <= 1'b0;
            flush_q     <= 1'b0;
        end
    end

    assign bus.PC_out         = pcOut_q;
    assign bus.result         = result_q;
    assign bus.rd_addr        = rdAddr_q;
    assign bus.rd_wr          = rdWr_q;
    assign bus.pipeline_valid = pipeValid_q;
    assign bus.flush          = flush_q;
    assign bus.flush_addr     = flushAddr_q;

endmodule
